// File: rtl/exibidor_cronometro.sv
// ============================================================================
//  Module   : exibidor_cronometro
//  Purpose  : Output stage of the shot clock. Converts the 5-bit remaining-
//             seconds value into two multiplexed active-low 7-segment digits
//             (tens blanked when zero, "--" for out-of-range values) and
//             stretches the countdown buzzer flag into a fixed-length horn
//             pulse.
//  Ports    : clock_in  - system clock, rising edge
//             reset     - synchronous, active-high
//             valor     - remaining seconds, 0..24 legal
//             buzzer_in - buzzer level from the countdown
//             segmentos - active-low segments {g,f,e,d,c,b,a}
//             anodos    - active-low digit enables, [0]=units, [1]=tens
//             buzina    - horn drive, active-high
//             erro      - high while the registered valor exceeds 24
//  Options  : EXIBIDOR_PISCA_EN - blink the display while the value is zero
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exibidor_cronometro #(
   parameter int SCAN_DIV    = 50000,
   parameter int BUZZ_CYCLES = 50000000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic       clock_in,
   input  logic       reset,
   input  logic [4:0] valor,
   input  logic       buzzer_in,
   output logic [6:0] segmentos,
   output logic [1:0] anodos,
   output logic       buzina,
   output logic       erro
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);

   localparam int c_BUZZ_W = (BUZZ_CYCLES > 2) ? $clog2(BUZZ_CYCLES) : 1;
   localparam logic [c_BUZZ_W-1:0] c_BUZZ_LOAD = c_BUZZ_W'(BUZZ_CYCLES - 1);

   localparam logic [6:0] c_SEG_DASH  = 7'b0111111;
   localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

   // Reject configurations the counters cannot represent.
   if (SCAN_DIV < 2 || BUZZ_CYCLES < 1 || BLINK_DIV < 1) begin : g_param_check
      $error("exibidor_cronometro: illegal parameter value");
   end

   // ------------------------------------------------------------------------
   // Input stage
   // ------------------------------------------------------------------------
   logic [4:0] v_q;
   logic       b_q;
   logic       b_prev_q;

   always_ff @(posedge clock_in) begin
      if (reset) begin
         v_q      <= '0;
         b_q      <= 1'b0;
         b_prev_q <= 1'b0;
      end else begin
         v_q      <= valor;
         b_q      <= buzzer_in;
         b_prev_q <= b_q;
      end
   end

   // ------------------------------------------------------------------------
   // Digit scan
   // ------------------------------------------------------------------------
   logic [c_SCAN_W-1:0] cnt_q, cnt_d;
   logic                sel_q, sel_d;

   always_comb begin
      cnt_d = cnt_q + c_SCAN_W'(1);
      sel_d = sel_q;
      if (cnt_q == c_SCAN_LAST) begin
         cnt_d = '0;
         sel_d = ~sel_q;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         cnt_q <= '0;
         sel_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sel_q <= sel_d;
      end
   end

   // ------------------------------------------------------------------------
   // Optional zero-value blink
   // ------------------------------------------------------------------------
   logic w_blink_on;

`ifdef EXIBIDOR_PISCA_EN
   localparam int c_BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);

   logic [c_BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic                 blink_on_q,  blink_on_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q + c_BLINK_W'(1);
      blink_on_d  = blink_on_q;
      if (v_q != 5'd0) begin
         // Any non-zero value restarts the blink in the visible phase.
         blink_cnt_d = '0;
         blink_on_d  = 1'b1;
      end else if (blink_cnt_q == c_BLINK_LAST) begin
         blink_cnt_d = '0;
         blink_on_d  = ~blink_on_q;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
      end
   end

   assign w_blink_on = blink_on_q;
`else
   assign w_blink_on = 1'b1;
`endif

   // ------------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------------
   function automatic logic [6:0] seg7(input logic [4:0] d);
      logic [6:0] s;
      case (d)
         5'd0:    s = 7'b1000000;
         5'd1:    s = 7'b1111001;
         5'd2:    s = 7'b0100100;
         5'd3:    s = 7'b0110000;
         5'd4:    s = 7'b0011001;
         5'd5:    s = 7'b0010010;
         5'd6:    s = 7'b0000010;
         5'd7:    s = 7'b1111000;
         5'd8:    s = 7'b0000000;
         5'd9:    s = 7'b0010000;
         default: s = c_SEG_BLANK;
      endcase
      return s;
   endfunction

   logic       w_err;
   logic [4:0] w_tens;
   logic [4:0] w_units;
   logic [4:0] w_digit;
   logic       w_blank;
   logic [6:0] w_seg;
   logic [1:0] w_an;

   always_comb begin
      w_err = (v_q > 5'd24);

      if (v_q >= 5'd20) begin
         w_tens  = 5'd2;
         w_units = v_q - 5'd20;
      end else if (v_q >= 5'd10) begin
         w_tens  = 5'd1;
         w_units = v_q - 5'd10;
      end else begin
         w_tens  = 5'd0;
         w_units = v_q;
      end

      // Only the tens digit is ever blanked; "--" overrides blanking.
      w_blank = sel_q & (w_tens == 5'd0) & ~w_err;
      w_digit = sel_q ? w_tens : w_units;

      if (w_err) begin
         w_seg = c_SEG_DASH;
      end else if (w_blank) begin
         w_seg = c_SEG_BLANK;
      end else begin
         w_seg = seg7(w_digit);
      end

      if (w_blank || !w_blink_on) begin
         w_an = 2'b11;
      end else begin
         w_an = sel_q ? 2'b01 : 2'b10;
      end
   end

   logic [6:0] seg_q;
   logic [1:0] an_q;
   logic       erro_q;

   always_ff @(posedge clock_in) begin
      if (reset) begin
         seg_q  <= c_SEG_BLANK;
         an_q   <= 2'b11;
         erro_q <= 1'b0;
      end else begin
         seg_q  <= w_seg;
         an_q   <= w_an;
         erro_q <= w_err;
      end
   end

   // ------------------------------------------------------------------------
   // Horn stretcher
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      SOANDO = 2'd1,
      ESPERA = 2'd2
   } horn_state_t;

   horn_state_t         state_q;
   logic [c_BUZZ_W-1:0] timer_q;
   logic                buz_q;

   // buzina is a registered copy of "state is SOANDO", which puts the pulse
   // one cycle after the state change and keeps its length equal to the
   // number of cycles spent in SOANDO.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q <= OCIOSO;
         timer_q <= '0;
         buz_q   <= 1'b0;
      end else begin
         buz_q <= (state_q == SOANDO);
         case (state_q)
            OCIOSO: begin
               if (b_q && !b_prev_q) begin
                  timer_q <= c_BUZZ_LOAD;
                  state_q <= SOANDO;
               end
            end
            SOANDO: begin
               if (timer_q == '0) begin
                  // A flag still high must drop before another pulse.
                  state_q <= b_q ? ESPERA : OCIOSO;
               end else begin
                  timer_q <= timer_q - c_BUZZ_W'(1);
               end
            end
            ESPERA: begin
               if (!b_q) begin
                  state_q <= OCIOSO;
               end
            end
            default: state_q <= OCIOSO;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign segmentos = seg_q;
   assign anodos    = an_q;
   assign erro      = erro_q;
   assign buzina    = buz_q;

endmodule

`default_nettype wire
